// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - operand sequencer and product collector for the serial-parallel multiplier core
//
// Purpose:
//   Accepts one operand pair (in_x signed, in_y unsigned) over a valid/ready
//   handshake. Holds x on the core's parallel input and streams y LSB-first,
//   zero-filled to 2*SIZE bits. Deserialises the core's serial product into a
//   2*SIZE-bit signed result, which is presented over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   in_valid, in_ready              operand handshake (in_ready high only in IDLE)
//   in_x [SIZE-1:0]                 multiplicand, signed
//   in_y [SIZE-1:0]                 multiplier, unsigned
//   out_valid, out_ready            product handshake
//   out_product [2*SIZE-1:0]        signed product, held stable while out_valid
//   busy                            high while a multiplication is in flight
//   spm_rst, spm_x, spm_y, spm_p    clear, parallel x, serial y, serial p of the core

module spm_seq #(
    parameter int SIZE = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     in_x,
    input  logic [SIZE-1:0]     in_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   out_product,
    output logic                busy,
    output logic                spm_rst,
    output logic [SIZE-1:0]     spm_x,
    output logic                spm_y,
    input  logic                spm_p
);

    localparam int CNT_W = $clog2(2*SIZE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2*SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    counter;
    logic [SIZE-1:0]     x_reg;
    logic [SIZE-1:0]     y_sreg;
    logic [2*SIZE-1:0]   prod_sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CLR;
            CLR:     state_nxt = SHIFT;
            SHIFT:   if (counter == LAST) state_nxt = TAIL;
            TAIL:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The core answers one cycle late: the y bit applied at counter k shows up
    // as product bit k during counter k+1. So the first SHIFT cycle has nothing
    // to capture, and TAIL captures the final (MSB) bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter   <= '0;
            x_reg     <= '0;
            y_sreg    <= '0;
            prod_sreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= in_x;
                        y_sreg    <= in_y;
                        prod_sreg <= '0;
                    end
                end
                CLR: begin
                    counter <= '0;
                end
                SHIFT: begin
                    // Zero fill supplies the upper SIZE y bits to the core.
                    y_sreg  <= {1'b0, y_sreg[SIZE-1:1]};
                    counter <= counter + CNT_W'(1);
                    if (counter != '0) begin
                        prod_sreg <= {spm_p, prod_sreg[2*SIZE-1:1]};
                    end
                end
                TAIL: begin
                    prod_sreg <= {spm_p, prod_sreg[2*SIZE-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign busy        = (state == CLR) || (state == SHIFT) || (state == TAIL);
    assign spm_rst     = (state == IDLE) || (state == CLR);
    assign spm_x       = x_reg;
    assign spm_y       = (state == SHIFT) ? y_sreg[0] : 1'b0;
    assign out_product = prod_sreg;

endmodule

// File: tb/tb_spm_seq.sv
// tb/tb_spm_seq.sv - bench for spm_seq with a behavioural serial multiplier core

module tb_spm_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    // SIZE=8 instance
    logic        iv8 = 1'b0, or8 = 1'b0;
    logic [7:0]  ix8 = '0, iy8 = '0;
    logic        ir8, ov8, busy8, sr8, sy8;
    logic [15:0] op8;
    logic [7:0]  sx8;
    logic        sp8;

    // SIZE=16 instance
    logic        iv16 = 1'b0, or16 = 1'b0;
    logic [15:0] ix16 = '0, iy16 = '0;
    logic        ir16, ov16, busy16, sr16, sy16;
    logic [31:0] op16;
    logic [15:0] sx16;
    logic        sp16;

    spm_seq #(.SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_x(ix8), .in_y(iy8),
        .out_valid(ov8), .out_ready(or8), .out_product(op8), .busy(busy8),
        .spm_rst(sr8), .spm_x(sx8), .spm_y(sy8), .spm_p(sp8)
    );

    spm_seq #(.SIZE(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16), .in_x(ix16), .in_y(iy16),
        .out_valid(ov16), .out_ready(or16), .out_product(op16), .busy(busy16),
        .spm_rst(sr16), .spm_x(sx16), .spm_y(sy16), .spm_p(sp16)
    );

    // Core model: accumulates the y bits seen since the clear and emits bit k of
    // signed(x) * y_so_far one cycle after y bit k was applied.
    function automatic logic core_bit(input longint sx, input longint ya, input int k);
        longint pr;
        pr = sx * ya;
        return pr[k];
    endfunction

    int     k8 = 0, k16 = 0;
    longint ya8 = 0, ya16 = 0;

    always @(posedge clk) begin
        if (sr8) begin
            k8 <= 0; ya8 <= 0; sp8 <= 1'b0;
        end else begin
            ya8 <= ya8 | (longint'(sy8) << k8);
            sp8 <= core_bit(longint'($signed(sx8)), ya8 | (longint'(sy8) << k8), k8);
            if (k8 < 62) k8 <= k8 + 1;
        end
    end

    always @(posedge clk) begin
        if (sr16) begin
            k16 <= 0; ya16 <= 0; sp16 <= 1'b0;
        end else begin
            ya16 <= ya16 | (longint'(sy16) << k16);
            sp16 <= core_bit(longint'($signed(sx16)), ya16 | (longint'(sy16) << k16), k16);
            if (k16 < 62) k16 <= k16 + 1;
        end
    end

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
        longint pr;
        pr = longint'($signed(x)) * longint'({56'd0, y});
        return pr[15:0];
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y);
        longint pr;
        pr = longint'($signed(x)) * longint'({48'd0, y});
        return pr[31:0];
    endfunction

    // Drive an operand pair and return #1 after the accepting edge.
    task automatic send8(input logic [7:0] x, input logic [7:0] y, input bit keep_valid);
        int t;
        iv8 = 1'b1; ix8 = x; iy8 = y; t = 0;
        while (ir8 !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        n_total++;
        if (ir8 !== 1'b1) $display("FAIL send8_ready got %b want 1", ir8);
        else n_pass++;
        @(posedge clk); #1;
        if (!keep_valid) iv8 = 1'b0;
    endtask

    // Count edges from the current point until out_valid is seen.
    task automatic wait8(output int lat);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (ir8 !== 1'b1) $display("FAIL rst_in_ready got %b want 1", ir8); else n_pass++;
        n_total++; if (ov8 !== 1'b0) $display("FAIL rst_out_valid got %b want 0", ov8); else n_pass++;
        n_total++; if (busy8 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy8); else n_pass++;
        n_total++; if (sr8 !== 1'b1) $display("FAIL rst_spm_rst got %b want 1", sr8); else n_pass++;
        n_total++; if (sy8 !== 1'b0) $display("FAIL rst_spm_y got %b want 0", sy8); else n_pass++;
        n_total++; if (sx8 !== 8'h00) $display("FAIL rst_spm_x got %h want 00", sx8); else n_pass++;
        n_total++; if (op8 !== 16'h0) $display("FAIL rst_product got %h want 0000", op8); else n_pass++;
        n_total++; if (ir16 !== 1'b1 || ov16 !== 1'b0 || op16 !== 32'h0)
            $display("FAIL rst_dut16 got ready=%b valid=%b prod=%h want 1 0 0", ir16, ov16, op16);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed8();
        logic [7:0]  xs [4] = '{8'h32, 8'hCE, 8'h80, 8'h7F};
        logic [7:0]  ys [4] = '{8'hCE, 8'hCE, 8'hFF, 8'hFF};
        logic [15:0] ps [4] = '{16'h283C, 16'hD7C4, 16'h8080, 16'h7E81};
        int lat;
        or8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send8(xs[i], ys[i], 1'b0);
            n_total++;
            if (busy8 !== 1'b1 || sx8 !== xs[i])
                $display("FAIL dir_busy_x[%0d] got busy=%b x=%h want 1 %h", i, busy8, sx8, xs[i]);
            else n_pass++;
            wait8(lat);
            n_total++;
            if (lat != 18) $display("FAIL dir_latency[%0d] got %0d want 18", i, lat); else n_pass++;
            n_total++;
            if (op8 !== ps[i]) $display("FAIL dir_product[%0d] got %h want %h", i, op8, ps[i]); else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (ov8 !== 1'b0 || ir8 !== 1'b1)
                $display("FAIL dir_one_cycle[%0d] got valid=%b ready=%b want 0 1", i, ov8, ir8);
            else n_pass++;
        end
    endtask

    task automatic test_size16();
        logic [15:0] xs [2] = '{16'h8000, 16'h0000};
        logic [15:0] ys [2] = '{16'hFFFF, 16'hFFFF};
        logic [31:0] ps [2] = '{32'h80008000, 32'h00000000};
        int lat;
        or16 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iv16 = 1'b1; ix16 = xs[i]; iy16 = ys[i];
            n_total++;
            if (ir16 !== 1'b1) $display("FAIL w16_ready[%0d] got %b want 1", i, ir16); else n_pass++;
            @(posedge clk); #1;
            iv16 = 1'b0;
            lat = 0;
            while (ov16 !== 1'b1 && lat < 200) begin
                @(posedge clk); #1; lat++;
            end
            n_total++;
            if (lat != 34) $display("FAIL w16_latency[%0d] got %0d want 34", i, lat); else n_pass++;
            n_total++;
            if (op16 !== ps[i]) $display("FAIL w16_product[%0d] got %h want %h", i, op16, ps[i]); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  x1, y1, x2, y2;
        logic [15:0] held;
        int lat;
        x1 = 8'($urandom); y1 = 8'($urandom);
        x2 = 8'($urandom); y2 = 8'($urandom);
        or8 = 1'b0;
        send8(x1, y1, 1'b0);
        wait8(lat);
        held = op8;
        n_total++;
        if (op8 !== ref8(x1, y1)) $display("FAIL bp_product got %h want %h", op8, ref8(x1, y1)); else n_pass++;
        // A competing request arrives while the result is stalled.
        iv8 = 1'b1; ix8 = x2; iy8 = y2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (ov8 !== 1'b1 || op8 !== held || ir8 !== 1'b0)
                $display("FAIL bp_hold[%0d] got valid=%b prod=%h ready=%b want 1 %h 0", i, ov8, op8, ir8, held);
            else n_pass++;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1)
            $display("FAIL bp_no_accept_in_done got valid=%b ready=%b want 0 1", ov8, ir8);
        else n_pass++;
        @(posedge clk); #1;
        iv8 = 1'b0;
        n_total++;
        if (ir8 !== 1'b0 || busy8 !== 1'b1 || sx8 !== x2)
            $display("FAIL bp_accept_next got ready=%b busy=%b x=%h want 0 1 %h", ir8, busy8, sx8, x2);
        else n_pass++;
        wait8(lat);
        n_total++;
        if (op8 !== ref8(x2, y2)) $display("FAIL bp_second got %h want %h", op8, ref8(x2, y2)); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  x, y;
        logic [15:0] want_q [$];
        int acc [4];
        int lat;
        or8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = 8'($urandom); y = 8'($urandom);
            want_q.push_back(ref8(x, y));
            send8(x, y, 1'b1);
            acc[i] = cyc;
            if (i > 0) begin
                n_total++;
                if (acc[i] - acc[i-1] != 20)
                    $display("FAIL b2b_spacing[%0d] got %0d want 20", i, acc[i] - acc[i-1]);
                else n_pass++;
            end
            wait8(lat);
            n_total++;
            if (op8 !== want_q[0]) $display("FAIL b2b_product[%0d] got %h want %h", i, op8, want_q[0]);
            else n_pass++;
            void'(want_q.pop_front());
        end
        iv8 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat;
        or8 = 1'b1;
        send8(8'h7F, 8'h7F, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        n_total++;
        if (busy8 !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy8); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || sr8 !== 1'b1 ||
            sy8 !== 1'b0 || sx8 !== 8'h00 || op8 !== 16'h0)
            $display("FAIL abort_reset_vals got ready=%b valid=%b busy=%b rst=%b y=%b x=%h p=%h want 1 0 0 1 0 00 0000",
                     ir8, ov8, busy8, sr8, sy8, sx8, op8);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send8(8'd3, 8'd5, 1'b0);
        wait8(lat);
        n_total++;
        if (lat != 18) $display("FAIL abort_latency got %0d want 18", lat); else n_pass++;
        n_total++;
        if (op8 !== 16'h000F) $display("FAIL abort_next got %h want 000f", op8); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed8();
        test_size16();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
